bcd_count_ctrl: RTL and testbench
=================================

Name: bcd_count_ctrl

Overview:
Run/pause/clear sequencer for the two-digit BCD counter datapath on the lab board. It replaces the free-running clock divider with a single-clock prescaler that issues one-cycle advance strobes (cnt_en) and clear strobes (cnt_clr) to the counter. It latches the count limit, keeps a binary shadow count, detects terminal count, and supports one-shot and auto-reload modes. Inputs come from already-synchronized board switch levels.

Parameters:
PRESCALE, 16777216, CLK cycles per count tick (>=2); the bench uses 4.
MAX_W, 7, width of count limit and shadow count.
MAX_LIMIT, 99, clamp value for the latched limit (the counter has two BCD digits).

Ports:
CLK  in  1  system clock, 100 MHz.
RST  in  1  synchronous reset, active-high.
start_sw  in  1  start/resume level; acts on rising edge.
stop_sw  in  1  pause level; acts on rising edge.
clr_sw  in  1  clear level; acts on rising edge.
auto_reload  in  1  1 = wrap at limit, 0 = one-shot; sampled every cycle.
max_count_in  in  MAX_W  requested limit, binary.
cnt_en  out  1  one-cycle strobe: counter advances by one.
cnt_clr  out  1  one-cycle strobe: counter returns to 00.
max_count  out  MAX_W  latched, clamped limit.
count  out  MAX_W  binary shadow of the counter value.
running  out  1  high in RUN only.
done  out  1  high in DONE only.

Behaviour:
- Clock: one clock domain (CLK). Reset is synchronous and active-high (RST). All outputs are registered.
- Reset values: state=IDLE, prescaler=0, count=0, max_count=0, cnt_en=0, cnt_clr=0, running=0, done=0. The edge-detect history registers reset to 1, so a switch already high at reset produces no edge.
- Edge detection: an edge is current level=1 with previous sample=0. The action shows on outputs in the next cycle.
- Event priority each cycle: RST > clr edge > stop edge > start edge > tick.
- States:
  - IDLE: start edge latches limit L = min(max_count_in, MAX_LIMIT), sets count=0 and prescaler=0, pulses cnt_clr, then goes to RUN. If L=0, it goes to DONE instead (cnt_clr is still pulsed).
  - RUN: prescaler increments each cycle. When it reaches PRESCALE-1 it returns to 0 and a tick occurs.
    - Tick with count < L: cnt_en=1, count+1. If count+1 == L and auto_reload=0, go to DONE.
    - Tick with count == L (only possible when auto_reload=1): count=0, cnt_clr=1, cnt_en=0, stay in RUN.
    - Stop edge: go to PAUSE. The prescaler holds its value.
  - PAUSE: no strobes; prescaler and count are frozen. Start edge returns to RUN and resumes from the held prescaler value.
  - DONE: done=1, no strobes. Start edge restarts exactly as from IDLE, re-latching the limit.
- Clr edge in any state: go to IDLE, count=0, prescaler=0, pulse cnt_clr.
- Stop edge coinciding with a tick in RUN: the tick is suppressed and the prescaler holds at PRESCALE-1, so the tick fires in the first RUN cycle after resume.
- Invariants:
  - cnt_en and cnt_clr are never high together.
  - Each strobe is exactly one cycle wide.
  - count never exceeds max_count.
  - max_count changes only on a start from IDLE or DONE.
- RST mid-operation: all outputs return to reset values on the next edge. No cnt_clr is issued; the counter datapath is reset separately.

Test Plan:
1. Assert RST for 2 cycles with all switches low → every output 0. Hold start_sw=1 through reset release → no transition; state stays IDLE.
2. PRESCALE=4, auto_reload=0, max_count_in=5, start edge → one cnt_clr pulse, then 5 cnt_en pulses spaced 4 cycles apart, count steps 1..5. done=1 and running=0 after the 5th pulse; no further strobes over 40 cycles.
3. auto_reload=1, max_count_in=3 → count sequence 0,1,2,3,0,1… Each wrap produces cnt_clr and no cnt_en; 3 cnt_en per 16-cycle period; done stays 0.
4. Stop edge at count=2, hold 20 cycles → no strobes, count=2. Then start edge → next cnt_en arrives after the remaining prescaler cycles, not a full period. Stop coinciding with a tick → that tick is deferred to the first cycle after resume.
5. max_count_in=120 with start → max_count=99. max_count_in=0 with start → one cnt_clr, then DONE with no cnt_en.
6. clr, stop and start edges in the same cycle as a tick → IDLE, count=0, a single cnt_clr, no cnt_en. RST asserted mid-RUN → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/bcd_count_ctrl_if.sv
// Switch inputs and counter control outputs of the BCD count sequencer.
// master: board/switch side (drives levels, observes strobes).
// slave : the sequencer itself.
interface bcd_count_ctrl_if #(
    parameter int MAX_W = 7
);
    logic             start_sw;
    logic             stop_sw;
    logic             clr_sw;
    logic             auto_reload;
    logic [MAX_W-1:0] max_count_in;
    logic             cnt_en;
    logic             cnt_clr;
    logic [MAX_W-1:0] max_count;
    logic [MAX_W-1:0] count;
    logic             running;
    logic             done;

    modport master (
        output start_sw, stop_sw, clr_sw, auto_reload, max_count_in,
        input  cnt_en, cnt_clr, max_count, count, running, done
    );

    modport slave (
        input  start_sw, stop_sw, clr_sw, auto_reload, max_count_in,
        output cnt_en, cnt_clr, max_count, count, running, done
    );
endinterface

// File: rtl/bcd_count_ctrl.sv
// Run/pause/clear sequencer for the two-digit BCD counter.
// A prescaler turns CLK into count ticks; each tick becomes a one-cycle
// cnt_en (advance) or cnt_clr (wrap) strobe. A binary shadow of the
// counter value is kept here so terminal count can be detected locally.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | cleared, waiting for start
// RUN   | prescaler running, ticks produce strobes
// PAUSE | prescaler and count frozen, start resumes
// DONE  | one-shot limit reached, start restarts with a new limit
module bcd_count_ctrl #(
    parameter int PRESCALE  = 16777216,
    parameter int MAX_W     = 7,
    parameter int MAX_LIMIT = 99
) (
    input  logic             CLK,
    input  logic             RST,
    bcd_count_ctrl_if.slave  bus
);

    localparam int PRESC_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [MAX_W-1:0]   LIMIT_CLAMP = MAX_W'(MAX_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] w_presc_nxt;
    logic [MAX_W-1:0]   r_count;
    logic [MAX_W-1:0]   w_count_nxt;
    logic [MAX_W-1:0]   r_max;
    logic [MAX_W-1:0]   w_max_nxt;
    logic               r_cnt_en;
    logic               w_cnt_en_nxt;
    logic               r_cnt_clr;
    logic               w_cnt_clr_nxt;
    logic               r_running;
    logic               r_done;

    // Previous switch samples; reset high so a switch held through reset is not an edge.
    logic               r_start_d;
    logic               r_stop_d;
    logic               r_clr_d;

    logic               w_start_edge;
    logic               w_stop_edge;
    logic               w_clr_edge;
    logic               w_tick;
    logic [MAX_W-1:0]   w_limit;
    logic [MAX_W-1:0]   w_count_inc;

    assign w_start_edge = bus.start_sw & ~r_start_d;
    assign w_stop_edge  = bus.stop_sw  & ~r_stop_d;
    assign w_clr_edge   = bus.clr_sw   & ~r_clr_d;
    assign w_tick       = (r_presc == PRESC_LAST);
    assign w_limit      = (bus.max_count_in > LIMIT_CLAMP) ? LIMIT_CLAMP : bus.max_count_in;
    assign w_count_inc  = r_count + MAX_W'(1);

    // Switch history for rising-edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_start_d <= 1'b1;
            r_stop_d  <= 1'b1;
            r_clr_d   <= 1'b1;
        end else begin
            r_start_d <= bus.start_sw;
            r_stop_d  <= bus.stop_sw;
            r_clr_d   <= bus.clr_sw;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath updates; clr beats stop beats start beats tick.
    always_comb begin
        w_state_nxt   = r_state;
        w_presc_nxt   = r_presc;
        w_count_nxt   = r_count;
        w_max_nxt     = r_max;
        w_cnt_en_nxt  = 1'b0;
        w_cnt_clr_nxt = 1'b0;

        if (w_clr_edge) begin
            w_state_nxt   = IDLE;
            w_count_nxt   = '0;
            w_presc_nxt   = '0;
            w_cnt_clr_nxt = 1'b1;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_edge) begin
                        w_max_nxt     = w_limit;
                        w_count_nxt   = '0;
                        w_presc_nxt   = '0;
                        w_cnt_clr_nxt = 1'b1;
                        w_state_nxt   = (w_limit == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_stop_edge) begin
                        // Prescaler holds, so a tick lost to the stop fires right after resume.
                        w_state_nxt = PAUSE;
                    end else if (w_tick) begin
                        w_presc_nxt = '0;
                        if (r_count < r_max) begin
                            w_cnt_en_nxt = 1'b1;
                            w_count_nxt  = w_count_inc;
                            if ((w_count_inc == r_max) && !bus.auto_reload) begin
                                w_state_nxt = DONE;
                            end
                        end else begin
                            // Sitting at the limit in reload mode: wrap to 00.
                            w_count_nxt   = '0;
                            w_cnt_clr_nxt = 1'b1;
                        end
                    end else begin
                        w_presc_nxt = r_presc + PRESC_W'(1);
                    end
                end
                PAUSE: begin
                    if (w_start_edge) begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Registered datapath and outputs; status flags follow the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_presc   <= '0;
            r_count   <= '0;
            r_max     <= '0;
            r_cnt_en  <= 1'b0;
            r_cnt_clr <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_presc   <= w_presc_nxt;
            r_count   <= w_count_nxt;
            r_max     <= w_max_nxt;
            r_cnt_en  <= w_cnt_en_nxt;
            r_cnt_clr <= w_cnt_clr_nxt;
            r_running <= (w_state_nxt == RUN);
            r_done    <= (w_state_nxt == DONE);
        end
    end

    assign bus.cnt_en    = r_cnt_en;
    assign bus.cnt_clr   = r_cnt_clr;
    assign bus.max_count = r_max;
    assign bus.count     = r_count;
    assign bus.running   = r_running;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for the BCD count sequencer with PRESCALE=4.
module tb_bcd_count_ctrl;

    localparam int MAX_W = 7;

    logic CLK = 1'b0;
    logic RST;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_on   = 1'b0;

    always #5 CLK = ~CLK;

    bcd_count_ctrl_if #(.MAX_W(MAX_W)) bus ();

    bcd_count_ctrl #(
        .PRESCALE  (4),
        .MAX_W     (MAX_W),
        .MAX_LIMIT (99)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic             st;
        logic             sp;
        logic             cl;
        logic             ar;
        logic [MAX_W-1:0] max_in;
        logic             en;
        logic             clr;
        logic [MAX_W-1:0] max;
        logic [MAX_W-1:0] cnt;
        logic             run;
        logic             dn;
    } vec_t;

    vec_t vt [18];

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all(input string nm, input int en, input int clr, input int mx,
                           input int cnt, input int run, input int dn);
        chk({nm, "_en"},    bus.cnt_en,    en);
        chk({nm, "_clr"},   bus.cnt_clr,   clr);
        chk({nm, "_max"},   bus.max_count, mx);
        chk({nm, "_count"}, bus.count,     cnt);
        chk({nm, "_run"},   bus.running,   run);
        chk({nm, "_done"},  bus.done,      dn);
    endtask

    // Invariants watched on every falling edge.
    always @(negedge CLK) begin
        if (mon_on) begin
            chk("inv_en_clr_excl", bus.cnt_en & bus.cnt_clr, 0);
            chk("inv_count_le_max", (bus.count <= bus.max_count) ? 1 : 0, 1);
        end
    end

    initial begin
        int n_str;

        //      st    sp    cl    ar    max_in   en    clr   max     cnt   run   dn
        vt[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 7'd3,   1'b0, 1'b1, 7'd3,  7'd0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd3,   1'b0, 1'b0, 7'd3,  7'd0, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 7'd120, 1'b0, 1'b1, 7'd99, 7'd0, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 7'd120, 1'b0, 1'b0, 7'd99, 7'd0, 1'b1, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 7'd120, 1'b0, 1'b1, 7'd99, 7'd0, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd0,   1'b0, 1'b0, 7'd99, 7'd0, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 7'd0,   1'b0, 1'b1, 7'd0,  7'd0, 1'b0, 1'b1};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 7'd0,   1'b0, 1'b0, 7'd0,  7'd0, 1'b0, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 7'd0,  7'd0, 1'b0, 1'b1};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd7,   1'b0, 1'b1, 7'd7,  7'd0, 1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd7,   1'b0, 1'b0, 7'd7,  7'd0, 1'b1, 1'b0};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd7,   1'b0, 1'b0, 7'd7,  7'd0, 1'b1, 1'b0};
        vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd7,   1'b0, 1'b0, 7'd7,  7'd0, 1'b1, 1'b0};
        vt[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'd7,   1'b0, 1'b1, 7'd7,  7'd0, 1'b0, 1'b0};
        vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd7,   1'b0, 1'b0, 7'd7,  7'd0, 1'b0, 1'b0};
        vt[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd7,   1'b0, 1'b0, 7'd7,  7'd0, 1'b0, 1'b0};
        vt[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd7,   1'b0, 1'b0, 7'd7,  7'd0, 1'b0, 1'b0};
        vt[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd7,   1'b0, 1'b1, 7'd7,  7'd0, 1'b1, 1'b0};

        RST              = 1'b1;
        bus.start_sw     = 1'b0;
        bus.stop_sw      = 1'b0;
        bus.clr_sw       = 1'b0;
        bus.auto_reload  = 1'b0;
        bus.max_count_in = '0;

        // Reset with switches low, then with start held through release.
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        mon_on = 1'b1;
        bus.start_sw = 1'b1;
        step();
        RST = 1'b0;
        step();
        step();
        step();
        chk_all("held_start", 0, 0, 0, 0, 0, 0);
        bus.start_sw = 1'b0;
        step();

        // One-shot to 5.
        bus.auto_reload  = 1'b0;
        bus.max_count_in = 7'd5;
        bus.start_sw     = 1'b1;
        step();
        chk_all("os_start", 0, 1, 5, 0, 1, 0);
        bus.start_sw = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk($sformatf("os_en_c%0d", i), bus.cnt_en, (i % 4 == 0) ? 1 : 0);
            chk($sformatf("os_count_c%0d", i), bus.count, i / 4);
        end
        chk("os_done", bus.done, 1);
        chk("os_running", bus.running, 0);
        n_str = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            n_str += bus.cnt_en + bus.cnt_clr;
        end
        chk("os_quiet_strobes", n_str, 0);
        chk("os_hold_count", bus.count, 5);

        // Auto-reload with limit 3, restarted from DONE.
        bus.auto_reload  = 1'b1;
        bus.max_count_in = 7'd3;
        bus.start_sw     = 1'b1;
        step();
        chk_all("ar_start", 0, 1, 3, 0, 1, 0);
        bus.start_sw = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            int k;
            step();
            k = i / 4;
            chk($sformatf("ar_en_c%0d", i), bus.cnt_en, ((i % 4 == 0) && (k % 4 != 0)) ? 1 : 0);
            chk($sformatf("ar_clr_c%0d", i), bus.cnt_clr, ((i % 4 == 0) && (k % 4 == 0)) ? 1 : 0);
            chk($sformatf("ar_count_c%0d", i), bus.count, k % 4);
            chk($sformatf("ar_done_c%0d", i), bus.done, 0);
        end

        // Pause at count 2 with one prescaler cycle already spent.
        for (int i = 0; i < 8; i++) step();
        chk("pz_count_before", bus.count, 2);
        step();
        bus.stop_sw = 1'b1;
        step();
        chk("pz_running", bus.running, 0);
        bus.stop_sw = 1'b0;
        n_str = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_str += bus.cnt_en + bus.cnt_clr;
        end
        chk("pz_quiet_strobes", n_str, 0);
        chk("pz_hold_count", bus.count, 2);
        bus.start_sw = 1'b1;
        step();
        chk("rs_running", bus.running, 1);
        chk("rs_en0", bus.cnt_en, 0);
        bus.start_sw = 1'b0;
        step();
        chk("rs_en1", bus.cnt_en, 0);
        step();
        chk("rs_en2", bus.cnt_en, 0);
        step();
        chk("rs_en3", bus.cnt_en, 1);
        chk("rs_count3", bus.count, 3);

        // Stop on the tick edge: tick deferred to first cycle after resume.
        step();
        step();
        step();
        bus.stop_sw = 1'b1;
        step();
        chk_all("st_tick", 0, 0, 3, 3, 0, 0);
        bus.stop_sw = 1'b0;
        step();
        step();
        step();
        chk("st_paused_clr", bus.cnt_clr, 0);
        bus.start_sw = 1'b1;
        step();
        chk_all("st_resume", 0, 0, 3, 3, 1, 0);
        step();
        chk_all("st_deferred_wrap", 0, 1, 3, 0, 1, 0);

        // Clamp, zero limit, simultaneous edges on a tick, idle stop.
        for (int v = 0; v < 18; v++) begin
            bus.start_sw     = vt[v].st;
            bus.stop_sw      = vt[v].sp;
            bus.clr_sw       = vt[v].cl;
            bus.auto_reload  = vt[v].ar;
            bus.max_count_in = vt[v].max_in;
            step();
            chk_all($sformatf("vec%0d", v), vt[v].en, vt[v].clr, vt[v].max, vt[v].cnt,
                    vt[v].run, vt[v].dn);
        end

        // Reset in the middle of a run.
        bus.start_sw = 1'b0;
        step();
        step();
        step();
        step();
        chk("mr_count", bus.count, 1);
        chk("mr_en", bus.cnt_en, 1);
        RST = 1'b1;
        step();
        chk_all("mid_rst", 0, 0, 0, 0, 0, 0);
        RST = 1'b0;
        step();

        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
